prog_mem_loadable: RTL and testbench

Parametrised successor to the BIP program memory. It is a synchronous-read instruction ROM/RAM that the CPU fetches from. It adds a byte-stream loader, fed by the UART receiver, that fills the memory with a program before the CPU is released. The block sits between the UART RX, the BIP control unit's PC/fetch path, and the top-level run/reset sequencing.

---
 rtl/bip_defs_pkg.sv | 16 +
 rtl/prog_mem_array.sv | 34 +++
 rtl/prog_mem_loadable.sv | 135 +++++++++++++
 tb/tb_prog_mem_loadable.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_defs_pkg.sv
// Shared BIP definitions: loader state encodings and default memory geometry
// used by the program memory, data memory and PC.
package bip_defs;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

  localparam int unsigned BIP_ADDR_W   = 32'd11;
  localparam int unsigned BIP_DATA_W   = 32'd16;
  // BIP HLT encoding doubles as the program terminator
  localparam logic [15:0] BIP_HLT_WORD = 16'h0000;

endpackage

// File: rtl/prog_mem_array.sv
// Parametrised single-write / single-read synchronous RAM with no reset,
// written so that synthesis can map it onto block RAM.
module prog_mem_array #(
  parameter int unsigned ADDR_W = 32'd11,
  parameter int unsigned DATA_W = 32'd16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port; a same-address write on this edge yields the old word
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_loadable.sv
// BIP program memory with a UART byte-stream loader that fills the array
// big-endian from address 0 until the HALT word or the end of memory.
module prog_mem_loadable
  import bip_defs::*;
#(
  parameter int unsigned        ADDR_W    = BIP_ADDR_W,
  parameter int unsigned        DATA_W    = BIP_DATA_W,
  parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(BIP_HLT_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count
);

  localparam int unsigned       BYTES     = DATA_W / 32'd8;
  localparam int unsigned       IDX_W     = (BYTES > 32'd1) ? $clog2(BYTES) : 32'd1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES - 32'd1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              fetch_ok_q, fetch_ok_d;
  logic              we_s;
  logic [DATA_W-1:0] rdata_s;

  prog_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (wptr_q),
    .wdata_i (asm_d),
    .raddr_i (fetch_addr),
    .rdata_o (rdata_s)
  );

  // Loader next-state: byte assembly, word write and termination
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    count_d = count_q;
    err_d   = err_q;
    we_s    = 1'b0;
    case (state_q)
      LD_IDLE, LD_DONE: begin
        if (load_start) begin
          state_d = LD_LOAD;
          wptr_d  = {ADDR_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          asm_d   = {DATA_W{1'b0}};
          count_d = {(ADDR_W+1){1'b0}};
          err_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      LD_LOAD: begin
        if (rx_valid) begin
          asm_d = (asm_q << 8) | DATA_W'(rx_data);
          if (idx_q == LAST_IDX) begin
            we_s    = 1'b1;
            idx_d   = {IDX_W{1'b0}};
            wptr_d  = wptr_q + ADDR_W'(1'b1);
            count_d = count_q + (ADDR_W+1)'(1'b1);
            if (asm_d == HALT_WORD) begin
              state_d = LD_DONE;
            end else if (wptr_q == LAST_ADDR) begin
              // Memory full without a terminator: stop rather than wrap onto 0
              state_d = LD_DONE;
              err_d   = 1'b1;
            end else begin
              state_d = LD_LOAD;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1'b1);
          end
        end else begin
          state_d = LD_LOAD;
        end
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  // Fetch is exposed only once both the previous and next state are outside
  // LOAD, so the first word after a load is never a stale pre-write read.
  always_comb begin
    fetch_ok_d = (state_q != LD_LOAD) && (state_d != LD_LOAD);
  end

  // Loader and fetch-gate registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LD_IDLE;
      wptr_q     <= {ADDR_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      asm_q      <= {DATA_W{1'b0}};
      count_q    <= {(ADDR_W+1){1'b0}};
      err_q      <= 1'b0;
      fetch_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      count_q    <= count_d;
      err_q      <= err_d;
      fetch_ok_q <= fetch_ok_d;
    end
  end

  assign fetch_data = rdata_s & {DATA_W{fetch_ok_q}};
  assign load_busy  = (state_q == LD_LOAD);
  assign load_done  = (state_q == LD_DONE);
  assign load_err   = err_q;
  assign load_count = count_q;

endmodule

// File: tb/tb_prog_mem_loadable.sv
// Directed and randomized bench for prog_mem_loadable: a default-size instance
// plus an ADDR_W=3 instance for the memory-full case.
module tb_prog_mem_loadable;

  logic        clk;
  logic        rst_n;

  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [10:0] fetch_addr;
  logic [15:0] fetch_data;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [11:0] load_count;

  logic        s_load_start;
  logic [7:0]  s_rx_data;
  logic        s_rx_valid;
  logic [2:0]  s_fetch_addr;
  logic [15:0] s_fetch_data;
  logic        s_load_busy;
  logic        s_load_done;
  logic        s_load_err;
  logic [3:0]  s_load_count;

  int errors = 0;
  int checks = 0;

  // Reference model: words the bench has completely sent, by address
  logic [15:0] m_mem [2048];
  int          m_wptr;

  prog_mem_loadable dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .load_count (load_count)
  );

  prog_mem_loadable #(.ADDR_W(3)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (s_load_start),
    .rx_data    (s_rx_data),
    .rx_valid   (s_rx_valid),
    .fetch_addr (s_fetch_addr),
    .fetch_data (s_fetch_data),
    .load_busy  (s_load_busy),
    .load_done  (s_load_done),
    .load_err   (s_load_err),
    .load_count (s_load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit sm, input logic [7:0] b);
    if (sm) begin
      s_rx_data  = b;
      s_rx_valid = 1'b1;
    end else begin
      rx_data  = b;
      rx_valid = 1'b1;
    end
    tick();
    s_rx_valid = 1'b0;
    rx_valid   = 1'b0;
  endtask

  task automatic send_word(input bit sm, input logic [15:0] w, input bit gaps);
    send_byte(sm, w[15:8]);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    send_byte(sm, w[7:0]);
  endtask

  task automatic model_write(input logic [15:0] w);
    m_mem[m_wptr] = w;
    m_wptr++;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_wptr = 0;
  endtask

  task automatic fetch_check(input string tag, input int a);
    fetch_addr = 11'(a);
    tick();
    check(tag, {16'h0000, fetch_data}, {16'h0000, m_mem[a]});
  endtask

  initial begin
    logic [7:0]  basic [6];
    logic [15:0] w;
    int          nrand;

    basic[0] = 8'h08; basic[1] = 8'h05; basic[2] = 8'h18;
    basic[3] = 8'h03; basic[4] = 8'h00; basic[5] = 8'h00;

    rst_n = 1'b0;
    load_start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; fetch_addr = 11'd0;
    s_load_start = 1'b0; s_rx_data = 8'h00; s_rx_valid = 1'b0; s_fetch_addr = 3'd0;
    m_wptr = 0;

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_fetch_data", {16'h0000, fetch_data}, 32'h0);
    check("rst_busy", {31'd0, load_busy}, 32'd0);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
    check("rst_count", {20'd0, load_count}, 32'd0);

    // Bytes in IDLE are ignored
    send_byte(1'b0, 8'h77);
    check("idle_rx_busy", {31'd0, load_busy}, 32'd0);
    check("idle_rx_count", {20'd0, load_count}, 32'd0);

    // Basic load with fetch_addr held at 0 to observe busy gating
    fetch_addr = 11'd0;
    pulse_start();
    check("basic_busy", {31'd0, load_busy}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      send_byte(1'b0, basic[i]);
      if (i < 5) check("gate_fetch_zero", {16'h0000, fetch_data}, 32'h0);
      if (i % 2 == 1) model_write({basic[i-1], basic[i]});
    end
    check("basic_done", {31'd0, load_done}, 32'd1);
    check("basic_busy_low", {31'd0, load_busy}, 32'd0);
    check("basic_count", {20'd0, load_count}, 32'd3);
    check("gate_done_cycle", {16'h0000, fetch_data}, 32'h0);
    tick();
    check("gate_first_word", {16'h0000, fetch_data}, 32'h0805);
    fetch_check("basic_mem1", 1);
    fetch_check("basic_mem2", 2);

    // Randomized program: non-halt words then the terminator, with gaps
    nrand = 6;
    pulse_start();
    for (int k = 0; k < nrand; k++) begin
      w = 16'($urandom_range(1, 65535));
      send_word(1'b0, w, 1'b1);
      model_write(w);
    end
    send_word(1'b0, 16'h0000, 1'b1);
    model_write(16'h0000);
    check("rand_done", {31'd0, load_done}, 32'd1);
    check("rand_count", {20'd0, load_count}, 32'(m_wptr));
    for (int a = 0; a <= nrand; a++) fetch_check("rand_mem", a);

    // Reset mid-load: 3 words plus 1 byte, then async reset
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      w = 16'($urandom_range(1, 65535));
      send_word(1'b0, w, 1'b0);
      model_write(w);
    end
    send_byte(1'b0, 8'h5A);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, load_busy}, 32'd0);
    check("mid_rst_done", {31'd0, load_done}, 32'd0);
    check("mid_rst_count", {20'd0, load_count}, 32'd0);
    check("mid_rst_fetch", {16'h0000, fetch_data}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) fetch_check("mid_rst_mem", a);

    // Reload edge cases: start+byte together, start pulses mid-load
    pulse_start();
    send_word(1'b0, 16'h0000, 1'b0);
    check("pre_reload_done", {31'd0, load_done}, 32'd1);
    load_start = 1'b1;
    rx_data    = 8'hAA;
    rx_valid   = 1'b1;
    tick();
    load_start = 1'b0;
    rx_valid   = 1'b0;
    m_wptr     = 0;
    check("reload_busy", {31'd0, load_busy}, 32'd1);
    send_byte(1'b0, 8'h12);
    load_start = 1'b1;
    send_byte(1'b0, 8'h34);
    load_start = 1'b0;
    model_write(16'h1234);
    pulse_start();
    m_wptr = 1;
    send_byte(1'b0, 8'h00);
    pulse_start();
    m_wptr = 1;
    send_byte(1'b0, 8'h00);
    model_write(16'h0000);
    check("reload_done", {31'd0, load_done}, 32'd1);
    check("reload_count", {20'd0, load_count}, 32'd2);
    fetch_check("reload_mem0", 0);
    fetch_check("reload_mem1", 1);

    // Memory-full case on the 8-word instance
    s_load_start = 1'b1;
    tick();
    s_load_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send_word(1'b1, 16'h1111, 1'b1);
      if (k == 6) begin
        check("ovf_err_early", {31'd0, s_load_err}, 32'd0);
        check("ovf_busy_early", {31'd0, s_load_busy}, 32'd1);
      end
    end
    check("ovf_err", {31'd0, s_load_err}, 32'd1);
    check("ovf_done", {31'd0, s_load_done}, 32'd1);
    check("ovf_busy", {31'd0, s_load_busy}, 32'd0);
    check("ovf_count", {28'd0, s_load_count}, 32'd8);
    send_word(1'b1, 16'h2222, 1'b0);
    check("ovf_extra_count", {28'd0, s_load_count}, 32'd8);
    check("ovf_extra_err", {31'd0, s_load_err}, 32'd1);
    s_fetch_addr = 3'd0;
    tick();
    check("ovf_mem0", {16'h0000, s_fetch_data}, 32'h1111);
    s_fetch_addr = 3'd7;
    tick();
    check("ovf_mem7", {16'h0000, s_fetch_data}, 32'h1111);
    s_load_start = 1'b1;
    tick();
    s_load_start = 1'b0;
    check("restart_err_clr", {31'd0, s_load_err}, 32'd0);
    check("restart_count_clr", {28'd0, s_load_count}, 32'd0);
    send_word(1'b1, 16'h0000, 1'b0);
    check("restart_done", {31'd0, s_load_done}, 32'd1);
    check("restart_count", {28'd0, s_load_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
